// File: rtl/i2s_tx_fifo.sv
// Four-entry stereo sample FIFO feeding an I2S serialiser; pops once per 64-bit frame.
// Define I2S_TX_FIFO_HOLD_EN to repeat the last sample on underflow instead of outputting silence.
module i2s_tx_fifo (
  input  logic        ck,
  input  logic        rst,
  input  logic        en,
  input  logic [5:0]  frame_posn,
  input  logic        in_valid,
  input  logic [15:0] in_left,
  input  logic [15:0] in_right,
  output logic        in_ready,
  output logic [15:0] left,
  output logic [15:0] right,
  output logic [2:0]  level,
  output logic        underflow,
  output logic [7:0]  xrun_count
);

  localparam logic [2:0] DEPTH = 3'd4;

  logic [31:0] mem_q [4];
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  level_q, level_d;
  logic [15:0] left_q, left_d;
  logic [15:0] right_q, right_d;
  logic        underflow_q, underflow_d;
  logic [7:0]  xrun_q, xrun_d;

  logic push;
  logic pop;
  logic pop_eff;

  // Pop on the last bit of the frame so the new sample is stable before the
  // serialiser loads left at position 0 and right at position 32.
  assign pop      = en && (frame_posn == 6'd63);
  assign pop_eff  = pop && (level_q != 3'd0);
  assign in_ready = !rst && (level_q < DEPTH);
  assign push     = in_valid && in_ready;

  // NOTE: every variable gets its default first, so no path through this block can infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    left_d      = left_q;
    right_d     = right_q;
    underflow_d = 1'b0;
    xrun_d      = xrun_q;
    level_d     = level_q + 3'(push) - 3'(pop_eff);

    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end

    if (pop) begin
      if (level_q != 3'd0) begin
        left_d   = mem_q[rd_ptr_q][31:16];
        right_d  = mem_q[rd_ptr_q][15:0];
        rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
        // A sample pushed in this same cycle is not yet visible to the pop.
        underflow_d = 1'b1;
        if (xrun_q != 8'hFF) begin
          xrun_d = xrun_q + 8'd1;
        end
`ifdef I2S_TX_FIFO_HOLD_EN
        left_d  = left_q;
        right_d = right_q;
`else
        left_d  = 16'h0000;
        right_d = 16'h0000;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge ck) begin
    if (rst) begin
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      level_q     <= 3'd0;
      left_q      <= 16'h0000;
      right_q     <= 16'h0000;
      underflow_q <= 1'b0;
      xrun_q      <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      left_q      <= left_d;
      right_q     <= right_d;
      underflow_q <= underflow_d;
      xrun_q      <= xrun_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and level is enough to discard stale entries.
  always_ff @(posedge ck) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_left, in_right};
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign level      = level_q;
  assign underflow  = underflow_q;
  assign xrun_count = xrun_q;

endmodule

// File: tb/tb_i2s_tx_fifo.sv
// Directed self-checking bench for i2s_tx_fifo; expectations follow I2S_TX_FIFO_HOLD_EN when defined.
module tb_i2s_tx_fifo;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [5:0]  frame_posn = 6'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_left = 16'h0000;
  logic [15:0] in_right = 16'h0000;
  logic        in_ready;
  logic [15:0] left;
  logic [15:0] right;
  logic [2:0]  level;
  logic        underflow;
  logic [7:0]  xrun_count;

  int checks = 0;
  int failures = 0;
  int exp_xrun = 0;
  logic [15:0] last_l = 16'h0000;
  logic [15:0] last_r = 16'h0000;

  i2s_tx_fifo dut (
    .ck(ck), .rst(rst), .en(en), .frame_posn(frame_posn),
    .in_valid(in_valid), .in_left(in_left), .in_right(in_right),
    .in_ready(in_ready), .left(left), .right(right), .level(level),
    .underflow(underflow), .xrun_count(xrun_count)
  );

  always #5 ck = ~ck;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask

  task automatic set_pop(input logic p);
    en = p;
    frame_posn = p ? 6'd63 : 6'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_left = 16'hDEAD;
    in_right = 16'hBEEF;
    cyc();
    cyc();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if ({left, right} !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {left, right}); end
    checks++; if (xrun_count !== 8'd0 || underflow !== 1'b0) begin failures++; $display("FAIL reset_xrun: got %0d/%b want 0/0", xrun_count, underflow); end
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    checks++; if (level !== 3'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL reset_release: level %0d ready %b want 0/1", level, in_ready); end
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_left = 16'h1234; in_right = 16'hABCD;
    cyc();
    checks++; if (level !== 3'd1) begin failures++; $display("FAIL basic_push_level: got %0d want 1", level); end
    in_valid = 1'b0;
    set_pop(1'b1);
    cyc();
    set_pop(1'b0);
    checks++; if (left !== 16'h1234 || right !== 16'hABCD) begin failures++; $display("FAIL basic_pop_data: got %h/%h want 1234/abcd", left, right); end
    checks++; if (level !== 3'd0 || underflow !== 1'b0) begin failures++; $display("FAIL basic_pop_state: level %0d uf %b want 0/0", level, underflow); end
    last_l = 16'h1234; last_r = 16'hABCD;
  endtask

  task automatic test_en_gating();
    in_valid = 1'b1; in_left = 16'h1111; in_right = 16'h2222;
    cyc();
    in_valid = 1'b0;
    en = 1'b0; frame_posn = 6'd63;
    cyc();
    checks++; if (level !== 3'd1 || left !== last_l) begin failures++; $display("FAIL en_low_no_pop: level %0d left %h want 1/%h", level, left, last_l); end
    en = 1'b1; frame_posn = 6'd62;
    cyc();
    checks++; if (level !== 3'd1 || right !== last_r) begin failures++; $display("FAIL posn62_no_pop: level %0d right %h want 1/%h", level, right, last_r); end
    set_pop(1'b1);
    cyc();
    set_pop(1'b0);
    checks++; if (left !== 16'h1111 || right !== 16'h2222 || level !== 3'd0) begin failures++; $display("FAIL en_pop: got %h/%h lvl %0d want 1111/2222 lvl 0", left, right, level); end
    last_l = 16'h1111; last_r = 16'h2222;
  endtask

  task automatic test_fill_and_full_pop();
    logic [15:0] el, er;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_left = 16'h0100 + 16'(i);
      in_right = 16'h0200 + 16'(i);
      if (i <= 4) cyc();
    end
    cyc();
    cyc();
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL fill_level: got %0d want 4", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready: got %b want 0", in_ready); end
    // Pop while full with the fifth sample still offered: push must be refused.
    set_pop(1'b1);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_ready: got %b want 0", in_ready); end
    cyc();
    set_pop(1'b0);
    checks++; if (level !== 3'd3 || in_ready !== 1'b1) begin failures++; $display("FAIL full_pop_after: level %0d ready %b want 3/1", level, in_ready); end
    checks++; if (left !== 16'h0101 || right !== 16'h0201) begin failures++; $display("FAIL full_pop_data: got %h/%h want 0101/0201", left, right); end
    cyc();
    in_valid = 1'b0;
    checks++; if (level !== 3'd4) begin failures++; $display("FAIL refill_level: got %0d want 4", level); end
    set_pop(1'b1);
    for (int i = 2; i <= 5; i++) begin
      cyc();
      el = 16'h0100 + 16'(i);
      er = 16'h0200 + 16'(i);
      checks++; if (left !== el || right !== er) begin failures++; $display("FAIL drain_order%0d: got %h/%h want %h/%h", i, left, right, el, er); end
    end
    set_pop(1'b0);
    checks++; if (level !== 3'd0 || underflow !== 1'b0) begin failures++; $display("FAIL drain_end: level %0d uf %b want 0/0", level, underflow); end
    last_l = 16'h0105; last_r = 16'h0205;
  endtask

  task automatic test_underflow();
    logic [15:0] el, er;
`ifdef I2S_TX_FIFO_HOLD_EN
    el = last_l; er = last_r;
`else
    el = 16'h0000; er = 16'h0000;
`endif
    set_pop(1'b1);
    cyc();
    set_pop(1'b0);
    exp_xrun++;
    checks++; if (underflow !== 1'b1 || xrun_count !== 8'(exp_xrun)) begin failures++; $display("FAIL uf_pulse: uf %b xrun %0d want 1/%0d", underflow, xrun_count, exp_xrun); end
    checks++; if (left !== el || right !== er) begin failures++; $display("FAIL uf_data: got %h/%h want %h/%h", left, right, el, er); end
    cyc();
    checks++; if (underflow !== 1'b0 || level !== 3'd0) begin failures++; $display("FAIL uf_one_cycle: uf %b level %0d want 0/0", underflow, level); end
    last_l = el; last_r = er;
  endtask

  task automatic test_simultaneous();
    logic [15:0] el, er;
    in_valid = 1'b1; in_left = 16'h0AAA; in_right = 16'h0BBB;
    cyc();
    in_left = 16'h0CCC; in_right = 16'h0DDD;
    cyc();
    in_left = 16'h7FFF; in_right = 16'h8000;
    set_pop(1'b1);
    cyc();
    in_valid = 1'b0;
    checks++; if (level !== 3'd2) begin failures++; $display("FAIL simul_level: got %0d want 2", level); end
    checks++; if (left !== 16'h0AAA || right !== 16'h0BBB) begin failures++; $display("FAIL simul_pop0: got %h/%h want 0aaa/0bbb", left, right); end
    cyc();
    checks++; if (left !== 16'h0CCC || right !== 16'h0DDD) begin failures++; $display("FAIL simul_pop1: got %h/%h want 0ccc/0ddd", left, right); end
    cyc();
    checks++; if (left !== 16'h7FFF || right !== 16'h8000 || level !== 3'd0) begin failures++; $display("FAIL simul_pop2: got %h/%h lvl %0d want 7fff/8000 lvl 0", left, right, level); end
    // Push and pop together on an empty FIFO: underflow, pushed entry survives.
    in_valid = 1'b1; in_left = 16'h1357; in_right = 16'h2468;
    cyc();
    in_valid = 1'b0;
    set_pop(1'b0);
    exp_xrun++;
`ifdef I2S_TX_FIFO_HOLD_EN
    el = 16'h7FFF; er = 16'h8000;
`else
    el = 16'h0000; er = 16'h0000;
`endif
    checks++; if (underflow !== 1'b1 || level !== 3'd1 || xrun_count !== 8'(exp_xrun)) begin failures++; $display("FAIL empty_push_pop: uf %b lvl %0d xrun %0d want 1/1/%0d", underflow, level, xrun_count, exp_xrun); end
    checks++; if (left !== el || right !== er) begin failures++; $display("FAIL empty_push_pop_data: got %h/%h want %h/%h", left, right, el, er); end
    set_pop(1'b1);
    cyc();
    set_pop(1'b0);
    checks++; if (left !== 16'h1357 || right !== 16'h2468 || level !== 3'd0) begin failures++; $display("FAIL empty_push_drain: got %h/%h lvl %0d want 1357/2468 lvl 0", left, right, level); end
  endtask

  task automatic test_saturate_and_reset();
    set_pop(1'b1);
    for (int i = 0; i < 300; i++) cyc();
    set_pop(1'b0);
    exp_xrun = (exp_xrun + 300 > 255) ? 255 : exp_xrun + 300;
    checks++; if (xrun_count !== 8'(exp_xrun) || underflow !== 1'b1) begin failures++; $display("FAIL xrun_saturate: got %0d uf %b want %0d/1", xrun_count, underflow, exp_xrun); end
    rst = 1'b1;
    in_valid = 1'b1; in_left = 16'h5555; in_right = 16'h6666;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_comb: got %b want 0", in_ready); end
    cyc();
    in_valid = 1'b0;
    rst = 1'b0;
    cyc();
    checks++; if (xrun_count !== 8'd0 || level !== 3'd0 || left !== 16'h0 || right !== 16'h0) begin failures++; $display("FAIL rst_clear: xrun %0d lvl %0d data %h/%h want 0/0/0/0", xrun_count, level, left, right); end
    set_pop(1'b1);
    cyc();
    set_pop(1'b0);
    checks++; if (underflow !== 1'b1 || xrun_count !== 8'd1) begin failures++; $display("FAIL first_pop_after_rst: uf %b xrun %0d want 1/1", underflow, xrun_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_en_gating();
    test_fill_and_full_pop();
    test_underflow();
    test_simultaneous();
    test_saturate_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
